// File: rtl/bus_req_master_if.sv
// Request, bus-beat and read-response signal bundle for bus_req_master.
// The master modport is the DUT view; the slave modport is the view of
// whatever drives requests and models the register-bus slave.
interface bus_req_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;

  logic       bus_hold;
  logic       bus_en;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  logic       rsp_valid;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_rdata;

  logic       busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, bus_hold, bus_rdata,
    output req_ready, bus_en, bus_wr, bus_addr, bus_wdata,
    output rsp_valid, rsp_addr, rsp_rdata, busy
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, bus_hold, bus_rdata,
    input  req_ready, bus_en, bus_wr, bus_addr, bus_wdata,
    input  rsp_valid, rsp_addr, rsp_rdata, busy
  );
endinterface

// File: rtl/bus_req_master.sv
// Upstream master for the 8-bit en/wr/addr/wdata/rdata register bus.
// Requests are queued in a small FIFO and issued one beat per cycle in order;
// read data comes back tagged with its address on a single-cycle pulse.
// A tag shift register of RD_LAT+1 stages tracks reads in flight: stage 0 is
// valid during the read beat itself, stage RD_LAT during the cycle whose
// closing edge samples bus_rdata.
module bus_req_master #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  bus_req_master_if.master bif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       bus_en_q, bus_en_d;
  logic       bus_wr_q, bus_wr_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;

  logic [RD_LAT:0] tag_v_q, tag_v_d;
  logic [7:0]      tag_addr_q [RD_LAT+1];
  logic [7:0]      tag_addr_d [RD_LAT+1];

  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_addr_q, rsp_addr_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  req_t head;

  // Ready comes only from the registered count, so a full FIFO refuses a
  // request even in a cycle where it is also popping. Gated by rst so the
  // port stays closed for as long as reset is held.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
  assign bif.req_ready = ~rst & ~full;
  assign push          = bif.req_valid & bif.req_ready;
  assign pop           = ~empty & ~bif.bus_hold;
  assign head          = mem_q[rd_ptr_q];

  // FIFO storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{wr: bif.req_wr, addr: bif.req_addr, wdata: bif.req_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next bus beat: the popped head entry, or an idle bus holding addr/wdata.
  always_comb begin
    bus_en_d    = pop;
    bus_wr_d    = pop & head.wr;
    bus_addr_d  = pop ? head.addr  : bus_addr_q;
    bus_wdata_d = pop ? head.wdata : bus_wdata_q;
  end

  // Read tag pipeline: a read enters stage 0 alongside its beat and shifts
  // one stage per cycle until it reaches the capture stage.
  always_comb begin
    tag_v_d[0]    = pop & ~head.wr;
    tag_addr_d[0] = head.addr;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_v_d[i]    = tag_v_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end
  end

  // Response capture; address and data hold between pulses.
  always_comb begin
    rsp_valid_d = tag_v_q[RD_LAT];
    rsp_addr_d  = tag_v_q[RD_LAT] ? tag_addr_q[RD_LAT] : rsp_addr_q;
    rsp_rdata_d = tag_v_q[RD_LAT] ? bif.bus_rdata      : rsp_rdata_q;
  end

  // FIFO payload has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      tag_v_q     <= '0;
      tag_addr_q  <= '{default: 8'h00};
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 8'h00;
      rsp_rdata_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bus_en_q    <= bus_en_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      tag_v_q     <= tag_v_d;
      tag_addr_q  <= tag_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bif.bus_en    = bus_en_q;
  assign bif.bus_wr    = bus_wr_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.rsp_valid = rsp_valid_q;
  assign bif.rsp_addr  = rsp_addr_q;
  assign bif.rsp_rdata = rsp_rdata_q;
  assign bif.busy      = ~empty | bus_en_q | (|tag_v_q);

endmodule

// File: tb/tb_bus_req_master.sv
// Directed bench for bus_req_master (DEPTH=4, RD_LAT=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_req_master;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  bus_req_master_if bif ();

  bus_req_master #(.DEPTH(4), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: read data is a fixed function of the address on the bus one cycle
  // earlier; 0x22 answers 0xA5, every other address answers addr ^ 0xF0.
  logic [7:0] beat_addr_d1;
  always @(posedge clk) beat_addr_d1 <= bif.bus_addr;

  function automatic logic [7:0] slave_f(input logic [7:0] a);
    return (a == 8'h22) ? 8'hA5 : (a ^ 8'hF0);
  endfunction

  assign bif.bus_rdata = slave_f(beat_addr_d1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bif.req_valid = 1'b0;
    bif.req_wr    = 1'b0;
    bif.req_addr  = 8'h00;
    bif.req_wdata = 8'h00;
  endtask

  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
    bif.req_valid = 1'b1;
    bif.req_wr    = wr;
    bif.req_addr  = a;
    bif.req_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bif.bus_hold = 1'b0;
    tick();
    tick();
    total_cnt++; if (bif.req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bif.req_ready); else pass_cnt++;
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL rst_bus_en: got %b want 0", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_wr !== 1'b0) $display("FAIL rst_bus_wr: got %b want 0", bif.bus_wr); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h00) $display("FAIL rst_bus_addr: got %h want 00", bif.bus_addr); else pass_cnt++;
    total_cnt++; if (bif.bus_wdata !== 8'h00) $display("FAIL rst_bus_wdata: got %h want 00", bif.bus_wdata); else pass_cnt++;
    total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bif.rsp_valid); else pass_cnt++;
    total_cnt++; if (bif.rsp_addr !== 8'h00) $display("FAIL rst_rsp_addr: got %h want 00", bif.rsp_addr); else pass_cnt++;
    total_cnt++; if (bif.rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata: got %h want 00", bif.rsp_rdata); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bif.busy); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (bif.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bif.req_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_single_write();
    push(1'b1, 8'h16, 8'h11);
    #1;
    total_cnt++; if (bif.req_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", bif.req_ready); else pass_cnt++;
    tick();
    drive_idle();
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL wr_n1_en: got %b want 0", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b1) $display("FAIL wr_n1_busy: got %b want 1", bif.busy); else pass_cnt++;
    tick();
    total_cnt++; if (bif.bus_en !== 1'b1) $display("FAIL wr_n2_en: got %b want 1", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_wr !== 1'b1) $display("FAIL wr_n2_wr: got %b want 1", bif.bus_wr); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h16) $display("FAIL wr_n2_addr: got %h want 16", bif.bus_addr); else pass_cnt++;
    total_cnt++; if (bif.bus_wdata !== 8'h11) $display("FAIL wr_n2_wdata: got %h want 11", bif.bus_wdata); else pass_cnt++;
    total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL wr_n2_rsp: got %b want 0", bif.rsp_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL wr_n3_en: got %b want 0", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_wr !== 1'b0) $display("FAIL wr_n3_wr: got %b want 0", bif.bus_wr); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h16) $display("FAIL wr_n3_addr_hold: got %h want 16", bif.bus_addr); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b0) $display("FAIL wr_n3_busy: got %b want 0", bif.busy); else pass_cnt++;
    total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL wr_n3_rsp: got %b want 0", bif.rsp_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_single_read();
    push(1'b0, 8'h22, 8'h00);
    tick();
    drive_idle();
    tick();
    total_cnt++; if (bif.bus_en !== 1'b1) $display("FAIL rd_beat_en: got %b want 1", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_wr !== 1'b0) $display("FAIL rd_beat_wr: got %b want 0", bif.bus_wr); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h22) $display("FAIL rd_beat_addr: got %h want 22", bif.bus_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL rd_b1_rsp: got %b want 0", bif.rsp_valid); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b1) $display("FAIL rd_b1_busy: got %b want 1", bif.busy); else pass_cnt++;
    tick();
    total_cnt++; if (bif.rsp_valid !== 1'b1) $display("FAIL rd_b2_rsp: got %b want 1", bif.rsp_valid); else pass_cnt++;
    total_cnt++; if (bif.rsp_addr !== 8'h22) $display("FAIL rd_b2_addr: got %h want 22", bif.rsp_addr); else pass_cnt++;
    total_cnt++; if (bif.rsp_rdata !== 8'hA5) $display("FAIL rd_b2_rdata: got %h want a5", bif.rsp_rdata); else pass_cnt++;
    tick();
    total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL rd_b3_rsp: got %b want 0", bif.rsp_valid); else pass_cnt++;
    total_cnt++; if (bif.rsp_rdata !== 8'hA5) $display("FAIL rd_b3_rdata_hold: got %h want a5", bif.rsp_rdata); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b0) $display("FAIL rd_b3_busy: got %b want 0", bif.busy); else pass_cnt++;
    tick();
  endtask

  // Reads 0x01..0x03 pushed in cycles 0..2; beats in 2..4; responses in 4..6.
  task automatic test_pipelined_reads();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) push(1'b0, 8'(c + 1), 8'h00);
      else drive_idle();
      #1;
      total_cnt++;
      if (bif.bus_en !== ((c >= 2 && c <= 4) ? 1'b1 : 1'b0))
        $display("FAIL pipe_en c%0d: got %b", c, bif.bus_en);
      else pass_cnt++;
      if (c >= 2 && c <= 4) begin
        total_cnt++;
        if (bif.bus_addr !== 8'(c - 1)) $display("FAIL pipe_addr c%0d: got %h want %h", c, bif.bus_addr, 8'(c - 1));
        else pass_cnt++;
      end
      total_cnt++;
      if (bif.rsp_valid !== ((c >= 4 && c <= 6) ? 1'b1 : 1'b0))
        $display("FAIL pipe_rsp c%0d: got %b", c, bif.rsp_valid);
      else pass_cnt++;
      if (c >= 4 && c <= 6) begin
        total_cnt++;
        if (bif.rsp_rdata !== (8'(c - 3) ^ 8'hF0)) $display("FAIL pipe_rdata c%0d: got %h want %h", c, bif.rsp_rdata, 8'(c - 3) ^ 8'hF0);
        else pass_cnt++;
        total_cnt++;
        if (bif.rsp_addr !== 8'(c - 3)) $display("FAIL pipe_rsp_addr c%0d: got %h want %h", c, bif.rsp_addr, 8'(c - 3));
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_full_hold();
    bif.bus_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 8'h10 + 8'(k), 8'hA0 + 8'(k));
      #1;
      total_cnt++; if (bif.req_ready !== 1'b1) $display("FAIL full_fill_ready k%0d: got %b want 1", k, bif.req_ready); else pass_cnt++;
      tick();
    end
    push(1'b1, 8'h14, 8'hA4);
    #1;
    total_cnt++; if (bif.req_ready !== 1'b0) $display("FAIL full_c4_ready: got %b want 0", bif.req_ready); else pass_cnt++;
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL full_c4_en: got %b want 0", bif.bus_en); else pass_cnt++;
    tick();
    total_cnt++; if (bif.req_ready !== 1'b0) $display("FAIL full_c5_ready: got %b want 0", bif.req_ready); else pass_cnt++;
    tick();
    bif.bus_hold = 1'b0;
    #1;
    total_cnt++; if (bif.req_ready !== 1'b0) $display("FAIL full_pop_ready: got %b want 0", bif.req_ready); else pass_cnt++;
    tick();
    bif.bus_hold = 1'b1;
    #1;
    total_cnt++; if (bif.req_ready !== 1'b1) $display("FAIL full_c7_ready: got %b want 1", bif.req_ready); else pass_cnt++;
    total_cnt++; if (bif.bus_en !== 1'b1) $display("FAIL full_c7_en: got %b want 1", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h10) $display("FAIL full_c7_addr: got %h want 10", bif.bus_addr); else pass_cnt++;
    total_cnt++; if (bif.bus_wdata !== 8'hA0) $display("FAIL full_c7_wdata: got %h want a0", bif.bus_wdata); else pass_cnt++;
    tick();
    drive_idle();
    bif.bus_hold = 1'b0;
    #1;
    total_cnt++; if (bif.req_ready !== 1'b0) $display("FAIL full_c8_ready: got %b want 0", bif.req_ready); else pass_cnt++;
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL full_c8_en: got %b want 0", bif.bus_en); else pass_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (bif.bus_en !== 1'b1) $display("FAIL full_drain_en i%0d: got %b want 1", i, bif.bus_en); else pass_cnt++;
      total_cnt++; if (bif.bus_addr !== 8'h11 + 8'(i)) $display("FAIL full_drain_addr i%0d: got %h want %h", i, bif.bus_addr, 8'h11 + 8'(i)); else pass_cnt++;
      total_cnt++; if (bif.bus_wdata !== 8'hA1 + 8'(i)) $display("FAIL full_drain_wdata i%0d: got %h want %h", i, bif.bus_wdata, 8'hA1 + 8'(i)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL full_end_en: got %b want 0", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b0) $display("FAIL full_end_busy: got %b want 0", bif.busy); else pass_cnt++;
    tick();
  endtask

  // Read 0x40 then writes 0x41..0x43 queued under hold; the read issues in
  // cycle 5 and reset is applied in cycle 6 while it is still in flight.
  task automatic test_reset_mid();
    bif.bus_hold = 1'b1;
    push(1'b0, 8'h40, 8'h00);
    tick();
    for (int k = 1; k < 4; k++) begin
      push(1'b1, 8'h40 + 8'(k), 8'h5A);
      tick();
    end
    drive_idle();
    bif.bus_hold = 1'b0;
    tick();
    bif.bus_hold = 1'b1;
    #1;
    total_cnt++; if (bif.bus_en !== 1'b1) $display("FAIL mid_beat_en: got %b want 1", bif.bus_en); else pass_cnt++;
    total_cnt++; if (bif.bus_wr !== 1'b0) $display("FAIL mid_beat_wr: got %b want 0", bif.bus_wr); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h40) $display("FAIL mid_beat_addr: got %h want 40", bif.bus_addr); else pass_cnt++;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (bif.busy !== 1'b1) $display("FAIL mid_pre_busy: got %b want 1", bif.busy); else pass_cnt++;
    tick();
    rst = 1'b0;
    bif.bus_hold = 1'b0;
    #1;
    total_cnt++; if (bif.req_ready !== 1'b1) $display("FAIL mid_post_ready: got %b want 1", bif.req_ready); else pass_cnt++;
    total_cnt++; if (bif.busy !== 1'b0) $display("FAIL mid_post_busy: got %b want 0", bif.busy); else pass_cnt++;
    total_cnt++; if (bif.bus_addr !== 8'h00) $display("FAIL mid_post_addr: got %h want 00", bif.bus_addr); else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      total_cnt++; if (bif.bus_en !== 1'b0) $display("FAIL mid_flush_en c%0d: got %b want 0", c, bif.bus_en); else pass_cnt++;
      total_cnt++; if (bif.rsp_valid !== 1'b0) $display("FAIL mid_flush_rsp c%0d: got %b want 0", c, bif.rsp_valid); else pass_cnt++;
      tick();
    end
  endtask

  // write 0x30/0x55, read 0x30, write 0x31/0x66 -> beats c2..c4, rsp in c5.
  task automatic test_mixed_order();
    logic       e_en, e_wr, e_rsp;
    logic [7:0] e_addr, e_wdata;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: push(1'b1, 8'h30, 8'h55);
        1: push(1'b0, 8'h30, 8'h00);
        2: push(1'b1, 8'h31, 8'h66);
        default: drive_idle();
      endcase
      e_en = 1'b0; e_wr = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
      case (c)
        2: begin e_en = 1'b1; e_wr = 1'b1; e_addr = 8'h30; e_wdata = 8'h55; end
        3: begin e_en = 1'b1; e_wr = 1'b0; e_addr = 8'h30; end
        4: begin e_en = 1'b1; e_wr = 1'b1; e_addr = 8'h31; e_wdata = 8'h66; end
        default: ;
      endcase
      e_rsp = (c == 5);
      #1;
      total_cnt++; if (bif.bus_en !== e_en) $display("FAIL mix_en c%0d: got %b want %b", c, bif.bus_en, e_en); else pass_cnt++;
      total_cnt++; if (bif.bus_wr !== e_wr) $display("FAIL mix_wr c%0d: got %b want %b", c, bif.bus_wr, e_wr); else pass_cnt++;
      if (e_en) begin
        total_cnt++; if (bif.bus_addr !== e_addr) $display("FAIL mix_addr c%0d: got %h want %h", c, bif.bus_addr, e_addr); else pass_cnt++;
        if (e_wr) begin
          total_cnt++; if (bif.bus_wdata !== e_wdata) $display("FAIL mix_wdata c%0d: got %h want %h", c, bif.bus_wdata, e_wdata); else pass_cnt++;
        end
      end
      total_cnt++; if (bif.rsp_valid !== e_rsp) $display("FAIL mix_rsp c%0d: got %b want %b", c, bif.rsp_valid, e_rsp); else pass_cnt++;
      if (e_rsp) begin
        total_cnt++; if (bif.rsp_addr !== 8'h30) $display("FAIL mix_rsp_addr: got %h want 30", bif.rsp_addr); else pass_cnt++;
        total_cnt++; if (bif.rsp_rdata !== 8'hC0) $display("FAIL mix_rsp_rdata: got %h want c0", bif.rsp_rdata); else pass_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    bif.bus_hold = 1'b0;
    drive_idle();
    test_reset();
    test_single_write();
    test_single_read();
    test_pipelined_reads();
    test_full_hold();
    test_reset_mid();
    test_mixed_order();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_req_master.md
Name: bus_req_master

Overview:
- Upstream bus master for the 8-bit en/wr/addr/wdata/rdata register bus used by the logging DUT.
- Accepts write and read requests from a testbench or sequencer through a valid/ready port, queues them in a small FIFO and issues one bus beat per cycle, in order.
- Returns read data, tagged with its address, on a single-cycle response port.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, at least 2.
- RD_LAT, 1: cycles from a read beat to valid bus_rdata; range 1..4.

Ports:
- clk  in  1  bus clock.
- rst  in  1  reset.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  8  request address.
- req_wdata  in  8  write data; ignored for reads.
- bus_hold  in  1  suppresses new bus beats while high.
- bus_en  out  1  bus beat strobe.
- bus_wr  out  1  beat is a write.
- bus_addr  out  8  beat address.
- bus_wdata  out  8  beat write data.
- bus_rdata  in  8  read data from the slave.
- rsp_valid  out  1  read response pulse.
- rsp_addr  out  8  address of the responding read.
- rsp_rdata  out  8  captured read data.
- busy  out  1  work is queued or in flight.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: while rst is sampled high, outputs are held as follows.
  - req_ready=0, bus_en=0, bus_wr=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rsp_addr=0, rsp_rdata=0, busy=0.
  - The FIFO is emptied and all in-flight reads are discarded.
  - In the first cycle after rst deasserts, req_ready=1.
- Accept:
  - A push occurs on a clock edge where req_valid & req_ready are both high.
  - req_ready = !full, a registered FIFO count compare. It does not depend on a pop in the same cycle, so a full FIFO never accepts, even while popping.
- Issue:
  - In a cycle where the FIFO is non-empty and bus_hold=0, the head entry is popped.
  - The registered bus outputs carry the popped entry in the next cycle, with bus_en=1 for exactly that one cycle.
  - Minimum latency: request accepted in cycle n gives bus_en=1 in cycle n+2.
  - Back-to-back beats occur every cycle while the FIFO is non-empty.
- Idle bus: bus_en=0 and bus_wr=0; bus_addr and bus_wdata hold their last values.
- bus_hold: sampled combinationally with the pop decision. It never truncates or cancels a beat already on the bus.
- Simultaneous push and pop: both take effect and the count is unchanged. A push into an empty FIFO is not bypassed to the bus in the same cycle.
- Reads:
  - For a read beat in cycle b, bus_rdata is sampled at the end of cycle b+RD_LAT.
  - rsp_valid=1 in cycle b+RD_LAT+1 for exactly one cycle, with rsp_addr equal to the beat address.
  - Reads are fully pipelined; track them with a tag shift register of length RD_LAT+1 carrying a valid bit and the address.
  - Responses are returned in issue order and have no backpressure.
  - rsp_addr and rsp_rdata hold their values between pulses.
- Writes: produce no response.
- busy = FIFO non-empty | bus_en | any read tag in flight.
- Reset mid-operation: everything is flushed. No rsp_valid pulse appears after the reset edge for any read issued before it.
- Widths: addresses and data are 8 bits with no arithmetic. FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

Test Plan:
- Single write: reset 2 cycles, then push write addr 0x16, wdata 0x11 in cycle n.
  - bus_en=1, bus_wr=1, bus_addr=0x16, bus_wdata=0x11 in cycle n+2 only.
  - No rsp_valid; busy falls in cycle n+3.
- Single read (RD_LAT=1): slave model drives 0xA5 for addr 0x22; read beat in cycle b.
  - rsp_valid=1 in cycle b+2, rsp_addr=0x22, rsp_rdata=0xA5, single pulse.
- Pipelined reads: push reads 0x01, 0x02, 0x03 back-to-back; slave returns addr^0xF0.
  - Three consecutive beats, then three consecutive rsp pulses with rdata 0xF1, 0xF2, 0xF3, in order.
- Full/hold: bus_hold=1, push writes 0x10..0x14 with req_valid held.
  - Four are accepted, then req_ready=0 and 0x14 waits.
  - Drop hold for one cycle: 0x10 issues, but 0x14 is not accepted that cycle. It is accepted the next cycle.
  - Final order on the bus is 0x10..0x14.
- Reset mid-operation: 3 writes queued and one read in flight; assert rst for 1 cycle.
  - No further bus_en, no rsp_valid, busy=0, req_ready=1 the cycle after deassert.
- Mixed order: write 0x30/0x55, read 0x30, write 0x31/0x66.
  - Beats in exact request order; one rsp with rsp_addr=0x30.
